// File: rtl/ram_arbiter_pkg.sv
// Shared client definitions for the RAM arbiter.
// Two clients, selected by a one-bit tag.
package ram_arbiter_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin arbiter.
// sel is the would-be winner; en can veto the grant.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   en,
    output logic [NUM_CLIENTS-1:0] gnt,
    output client_e                sel
);

    client_e last;

    // Pick the winner: sole requester, else the one not last granted
    always_comb begin
        sel = CLIENT0;
        case (req)
            2'b01:   sel = CLIENT0;
            2'b10:   sel = CLIENT1;
            2'b11:   sel = (last == CLIENT1) ? CLIENT0 : CLIENT1;
            default: sel = CLIENT0;
        endcase
    end

    // Grant only when someone asks and the caller allows it
    always_comb begin
        gnt = '0;
        if (en && (req != '0)) begin
            gnt = (sel == CLIENT1) ? 2'b10 : 2'b01;
        end
    end

    // Remember the last granted client; starts as client 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= CLIENT1;
        end else if (gnt != '0) begin
            last <= sel;
        end
    end

endmodule

// File: rtl/simple_dual_ram.sv
// Simple dual-port RAM: one write port, one read port.
// Read data is registered, valid the cycle after the address.
module simple_dual_ram #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            wclk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic            rclk,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [DEPTH];

    // Write port: store on the edge when enabled
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: register the addressed word every cycle
    always_ff @(posedge rclk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two clients sharing one simple dual-port RAM.
// Write and read ports each have their own round-robin arbiter.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int SIZE  = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            c0_wvalid,
    input  logic [AW-1:0]   c0_waddr,
    input  logic [SIZE-1:0] c0_wdata,
    output logic            c0_wready,
    input  logic            c0_rvalid_req,
    input  logic [AW-1:0]   c0_raddr,
    output logic            c0_rready,
    output logic            c0_rvalid,
    output logic [SIZE-1:0] c0_rdata,
    input  logic            c1_wvalid,
    input  logic [AW-1:0]   c1_waddr,
    input  logic [SIZE-1:0] c1_wdata,
    output logic            c1_wready,
    input  logic            c1_rvalid_req,
    input  logic [AW-1:0]   c1_raddr,
    output logic            c1_rready,
    output logic            c1_rvalid,
    output logic [SIZE-1:0] c1_rdata
);

    logic [NUM_CLIENTS-1:0] wreq;
    logic [NUM_CLIENTS-1:0] rreq;
    logic [NUM_CLIENTS-1:0] wgnt;
    logic [NUM_CLIENTS-1:0] rgnt;
    client_e                wsel;
    client_e                rsel;
    logic                   ram_we;
    logic [AW-1:0]          ram_waddr;
    logic [SIZE-1:0]        ram_wdata;
    logic [AW-1:0]          ram_raddr;
    logic [SIZE-1:0]        ram_rdata;
    logic                   hazard;
    logic                   pend_valid;
    client_e                pend_tag;

    // Requests are masked during reset so nothing is granted
    assign wreq = {c1_wvalid, c0_wvalid} & {2{rst_n}};
    assign rreq = {c1_rvalid_req, c0_rvalid_req} & {2{rst_n}};

    rr_arb2 u_warb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wreq),
        .en    (1'b1),
        .gnt   (wgnt),
        .sel   (wsel)
    );

    assign ram_we    = |wgnt;
    assign ram_waddr = (wsel == CLIENT1) ? c1_waddr : c0_waddr;
    assign ram_wdata = (wsel == CLIENT1) ? c1_wdata : c0_wdata;
    assign ram_raddr = (rsel == CLIENT1) ? c1_raddr : c0_raddr;

    // A read colliding with this cycle's write waits a cycle
    assign hazard = ram_we && (ram_raddr == ram_waddr);

    rr_arb2 u_rarb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rreq),
        .en    (!hazard),
        .gnt   (rgnt),
        .sel   (rsel)
    );

    assign c0_wready = wgnt[0];
    assign c1_wready = wgnt[1];
    assign c0_rready = rgnt[0];
    assign c1_rready = rgnt[1];

    simple_dual_ram #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .wclk  (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .rclk  (clk),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Track which client owns the read data arriving next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_tag   <= CLIENT0;
        end else begin
            pend_valid <= |rgnt;
            pend_tag   <= rsel;
        end
    end

    assign c0_rvalid = pend_valid && (pend_tag == CLIENT0);
    assign c1_rvalid = pend_valid && (pend_tag == CLIENT1);
    assign c0_rdata  = ram_rdata;
    assign c1_rdata  = ram_rdata;

endmodule
